// File: rtl/ahb_lite_master_if.sv
// Core request/response and AHB-Lite bus signals grouped for the single-outstanding initiator.
// The master modport is the initiator side; the slave modport is the core/fabric side.
interface ahb_lite_master_if;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic        req_write;
    logic [2:0]  req_size;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        rsp_timeout;
    logic [31:0] HADDR;
    logic [1:0]  HTRANS;
    logic        HWRITE;
    logic [2:0]  HSIZE;
    logic [2:0]  HBURST;
    logic [31:0] HWDATA;
    logic [31:0] HRDATA;
    logic        HREADY;
    logic [1:0]  HRESP;

    modport master (
        input  req_valid, req_addr, req_write, req_size, req_wdata,
        input  HRDATA, HREADY, HRESP,
        output req_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
        output HADDR, HTRANS, HWRITE, HSIZE, HBURST, HWDATA
    );

    modport slave (
        output req_valid, req_addr, req_write, req_size, req_wdata,
        output HRDATA, HREADY, HRESP,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
        input  HADDR, HTRANS, HWRITE, HSIZE, HBURST, HWDATA
    );
endinterface

// File: rtl/ahb_lite_master.sv
// Single-outstanding AHB-Lite initiator: one NONSEQ SINGLE transfer per core request,
// with byte-lane placement, error/misalignment reporting and a wait-state timeout.
module ahb_lite_master #(
    parameter int TIMEOUT_CYCLES = 256,
    parameter int CNT_W          = 16
) (
    input  logic              HCLK,
    input  logic              HRESET,
    ahb_lite_master_if.master bus
);

    localparam logic [1:0] HT_IDLE   = 2'b00;
    localparam logic [1:0] HT_NONSEQ = 2'b10;

    typedef enum logic [1:0] {S_IDLE, S_ADDR, S_DATA} state_t;

    state_t            r_state;
    logic [31:0]       r_haddr;
    logic [1:0]        r_htrans;
    logic              r_hwrite;
    logic [2:0]        r_hsize;
    logic [31:0]       r_hwdata;
    logic [31:0]       r_wbuf;
    logic              r_rsp_valid;
    logic [31:0]       r_rsp_rdata;
    logic              r_rsp_err;
    logic              r_rsp_timeout;
    logic [CNT_W-1:0]  r_cnt;

    logic [CNT_W-1:0]  w_cnt_inc;
    logic              w_timeout;

    function automatic logic f_legal(input logic [2:0] sz, input logic [1:0] a);
        logic ok;
        ok = 1'b0;
        case (sz)
            3'b000:  ok = 1'b1;
            3'b001:  ok = !a[0];
            3'b010:  ok = (a == 2'b00);
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

    function automatic logic [31:0] f_lanes(input logic [2:0] sz, input logic [31:0] w);
        logic [31:0] v;
        case (sz)
            3'b000:  v = {4{w[7:0]}};
            3'b001:  v = {2{w[15:0]}};
            default: v = w;
        endcase
        return v;
    endfunction

    function automatic logic [31:0] f_extract(input logic [31:0] d, input logic [2:0] sz,
                                              input logic [1:0] off);
        logic [31:0] v;
        v = '0;
        case (sz)
            3'b000: begin
                case (off)
                    2'd0:    v = {24'b0, d[7:0]};
                    2'd1:    v = {24'b0, d[15:8]};
                    2'd2:    v = {24'b0, d[23:16]};
                    default: v = {24'b0, d[31:24]};
                endcase
            end
            3'b001:  v = off[1] ? {16'b0, d[31:16]} : {16'b0, d[15:0]};
            default: v = d;
        endcase
        return v;
    endfunction

    // The abort fires on the edge that would bring the stall count to TIMEOUT_CYCLES.
    assign w_cnt_inc = r_cnt + 1'b1;
    assign w_timeout = (TIMEOUT_CYCLES != 0) && (w_cnt_inc == CNT_W'(TIMEOUT_CYCLES));

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            r_state       <= S_IDLE;
            r_htrans      <= HT_IDLE;
            r_haddr       <= '0;
            r_hwrite      <= 1'b0;
            r_hsize       <= '0;
            r_hwdata      <= '0;
            r_rsp_valid   <= 1'b0;
            r_rsp_rdata   <= '0;
            r_rsp_err     <= 1'b0;
            r_rsp_timeout <= 1'b0;
            r_cnt         <= '0;
        end else begin
            r_rsp_valid   <= 1'b0;
            r_rsp_rdata   <= '0;
            r_rsp_err     <= 1'b0;
            r_rsp_timeout <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (bus.req_valid) begin
                        if (f_legal(bus.req_size, bus.req_addr[1:0])) begin
                            r_haddr  <= bus.req_addr;
                            r_hwrite <= bus.req_write;
                            r_hsize  <= bus.req_size;
                            r_wbuf   <= f_lanes(bus.req_size, bus.req_wdata);
                            r_htrans <= HT_NONSEQ;
                            r_cnt    <= '0;
                            r_state  <= S_ADDR;
                        end else begin
                            r_rsp_valid <= 1'b1;
                            r_rsp_err   <= 1'b1;
                        end
                    end
                end
                S_ADDR: begin
                    if (bus.HREADY) begin
                        r_htrans <= HT_IDLE;
                        r_cnt    <= '0;
                        if (r_hwrite) r_hwdata <= r_wbuf;
                        r_state  <= S_DATA;
                    end else if (w_timeout) begin
                        r_htrans      <= HT_IDLE;
                        r_cnt         <= '0;
                        r_rsp_valid   <= 1'b1;
                        r_rsp_err     <= 1'b1;
                        r_rsp_timeout <= 1'b1;
                        r_state       <= S_IDLE;
                    end else begin
                        r_cnt <= w_cnt_inc;
                    end
                end
                S_DATA: begin
                    if (bus.HREADY) begin
                        r_cnt       <= '0;
                        r_rsp_valid <= 1'b1;
                        r_state     <= S_IDLE;
                        if (bus.HRESP != 2'b00) r_rsp_err <= 1'b1;
                        else if (!r_hwrite)
                            r_rsp_rdata <= f_extract(bus.HRDATA, r_hsize, r_haddr[1:0]);
                    end else if (w_timeout) begin
                        r_cnt         <= '0;
                        r_rsp_valid   <= 1'b1;
                        r_rsp_err     <= 1'b1;
                        r_rsp_timeout <= 1'b1;
                        r_state       <= S_IDLE;
                    end else begin
                        r_cnt <= w_cnt_inc;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.req_ready   = (r_state == S_IDLE) && !HRESET;
    assign bus.rsp_valid   = r_rsp_valid;
    assign bus.rsp_rdata   = r_rsp_rdata;
    assign bus.rsp_err     = r_rsp_err;
    assign bus.rsp_timeout = r_rsp_timeout;
    assign bus.HADDR       = r_haddr;
    assign bus.HTRANS      = r_htrans;
    assign bus.HWRITE      = r_hwrite;
    assign bus.HSIZE       = r_hsize;
    assign bus.HBURST      = 3'b000;
    assign bus.HWDATA      = r_hwdata;

endmodule
